// File: rtl/palette_pkg.sv
// Shared types and constants for the two-requester palette arbiter.
package palette_pkg;

    localparam int N_REQ   = 2;
    localparam int IDX_W   = 4;
    localparam int COLOR_W = 4;

    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        color_t red;
        color_t green;
        color_t blue;
    } rgb_t;

    typedef logic [$clog2(N_REQ)-1:0] req_id_t;

    // One registered response slot as seen downstream.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        rgb_t    rgb;
        logic    transparent;
    } rsp_t;

    // With two requesters the round-robin successor is simply the other one.
    function automatic req_id_t rr_other(input req_id_t id);
        return req_id_t'(~id);
    endfunction

endpackage

// File: rtl/palette_arbiter_if.sv
// Request, palette-lookup and response signals of the palette arbiter.
interface palette_arbiter_if #(
    parameter int BANK_W = 3
);
    import palette_pkg::*;

    // Requester side
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][IDX_W-1:0]  req_index;
    logic [N_REQ-1:0][BANK_W-1:0] req_bank;
    logic [N_REQ-1:0]             req_ready;

    // Shared combinational palette lookup
    logic [IDX_W-1:0]   pal_index;
    logic [BANK_W-1:0]  pal_bank;
    color_t             pal_red;
    color_t             pal_green;
    color_t             pal_blue;

    // Registered response
    logic    rsp_valid;
    req_id_t rsp_id;
    color_t  rsp_red;
    color_t  rsp_green;
    color_t  rsp_blue;
    logic    rsp_transparent;
    logic    rsp_ready;

    // Arbiter view
    modport slave (
        input  req_valid, req_index, req_bank,
        input  pal_red, pal_green, pal_blue,
        input  rsp_ready,
        output req_ready,
        output pal_index, pal_bank,
        output rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
    );

    // Requesters, palette ROM and downstream consumer view
    modport master (
        output req_valid, req_index, req_bank,
        output pal_red, pal_green, pal_blue,
        output rsp_ready,
        input  req_ready,
        input  pal_index, pal_bank,
        input  rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
    );

endinterface

// File: rtl/palette_rr_arbiter.sv
// Two-way round-robin grant decode with the last_grant history register.
module palette_rr_arbiter
    import palette_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic             slot_free_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_valid_o,
    output req_id_t          grant_id_o,
    output req_id_t          last_grant_o
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;
    req_id_t preferred;

    assign preferred = rr_other(last_grant_q);

    // Grant decode: prefer the requester not served last, else fall back to the other.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        grant_valid_o = 1'b0;
        grant_id_o    = last_grant_q;
        grant_o       = '0;
        if (rst_n_i && slot_free_i) begin
            if (req_valid_i[preferred]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = preferred;
            end else if (req_valid_i[last_grant_q]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = last_grant_q;
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_id_o] = 1'b1;
        end
        last_grant_d = grant_valid_o ? grant_id_o : last_grant_q;
    end

    // History register; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (!rst_n_i) begin
            last_grant_q <= req_id_t'(1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant_o = last_grant_q;

endmodule

// File: rtl/palette_arbiter.sv
// Arbitrates two sprite requesters onto one shared palette lookup and
// registers the looked-up colour into a single backpressured response slot.
module palette_arbiter
    import palette_pkg::*;
#(
    parameter logic [IDX_W-1:0] TRANSPARENT_INDEX = 4'h0,
    parameter int               BANK_W            = 3
) (
    input  logic          Clk,
    input  logic          Reset_n,
    palette_arbiter_if.slave bus
);

    logic             slot_free;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    req_id_t          grant_id;
    req_id_t          last_grant;
    req_id_t          sel;
    logic [IDX_W-1:0] pal_index;
    logic [BANK_W-1:0] pal_bank;
    rsp_t             rsp_q;
    rsp_t             rsp_d;

    // The slot can take a new response when empty or being drained this cycle.
    assign slot_free = !rsp_q.valid || bus.rsp_ready;

    palette_rr_arbiter u_rr (
        .clk_i         (Clk),
        .rst_n_i       (Reset_n),
        .req_valid_i   (bus.req_valid),
        .slot_free_i   (slot_free),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .last_grant_o  (last_grant)
    );

    assign bus.req_ready = grant;

    // Lookup mux follows the grant, or parks on last_grant when idle.
    assign sel       = grant_valid ? grant_id : last_grant;
    assign pal_index = bus.req_index[sel];
    assign pal_bank  = bus.req_bank[sel];
    assign bus.pal_index = pal_index;
    assign bus.pal_bank  = pal_bank;

    // Next response: load on transfer, drop valid when drained, otherwise hold.
    always_comb begin
        rsp_d = rsp_q;
        if (grant_valid) begin
            rsp_d.valid       = 1'b1;
            rsp_d.id          = grant_id;
            rsp_d.rgb         = '{red: bus.pal_red, green: bus.pal_green, blue: bus.pal_blue};
            rsp_d.transparent = (pal_index == TRANSPARENT_INDEX);
        end else if (bus.rsp_ready) begin
            rsp_d.valid = 1'b0;
        end
    end

    // Response register; reset discards any held response.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign bus.rsp_valid       = rsp_q.valid;
    assign bus.rsp_id          = rsp_q.id;
    assign bus.rsp_red         = rsp_q.rgb.red;
    assign bus.rsp_green       = rsp_q.rgb.green;
    assign bus.rsp_blue        = rsp_q.rgb.blue;
    assign bus.rsp_transparent = rsp_q.transparent;

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_palette_arbiter;
    import palette_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    palette_arbiter_if #(.BANK_W(3)) bus ();

    palette_arbiter #(
        .TRANSPARENT_INDEX (4'h0),
        .BANK_W            (3)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Palette ROM model: fixed base colours, bank tints red and blue.
    function automatic rgb_t pal_color(input logic [3:0] idx, input logic [2:0] bank);
        rgb_t c;
        case (idx)
            4'h0:    c = 12'hFFF;
            4'h1:    c = 12'h000;
            4'h4:    c = 12'h6DF;
            default: c = {idx, ~idx, idx ^ 4'h5};
        endcase
        c.red  = c.red  ^ {1'b0, bank};
        c.blue = c.blue ^ {1'b0, bank};
        return c;
    endfunction

    always_comb begin
        rgb_t c;
        c = pal_color(bus.pal_index, bus.pal_bank);
        bus.pal_red   = c.red;
        bus.pal_green = c.green;
        bus.pal_blue  = c.blue;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] i0, input logic [3:0] i1,
                         input logic [2:0] b0, input logic [2:0] b1, input logic rr);
        bus.req_valid    = v;
        bus.req_index[0] = i0;
        bus.req_index[1] = i1;
        bus.req_bank[0]  = b0;
        bus.req_bank[1]  = b1;
        bus.rsp_ready    = rr;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_rsp(input string name, input logic id, input rgb_t rgb, input logic tr);
        check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({name, "_rsp_id"},    32'(bus.rsp_id), 32'(id));
        check({name, "_rsp_rgb"},   32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'(rgb));
        check({name, "_rsp_tr"},    32'(bus.rsp_transparent), 32'(tr));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        drive(2'b00, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0);
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [3:0] i0, i1;
        logic [2:0] b0, b1;
        logic       rr;
        logic [1:0] exp_ready;
        logic [3:0] exp_pidx;
        logic       exp_rv;
        logic       exp_id;
        rgb_t       exp_rgb;
        logic       exp_tr;
    } vec_t;

    vec_t vecs[9];

    // Random-phase model state
    logic       cv[2];
    logic [3:0] ci[2];
    logic [2:0] cb[2];
    logic       acc[2];
    logic       rr_r;
    int         m_last;
    logic       m_valid;
    logic       m_id;
    rgb_t       m_rgb;
    logic       m_tr;
    int         cand[$];
    logic       got;
    int         g;
    logic [1:0] exp_ready;
    rgb_t       held_rgb;

    initial begin
        // v, i0, i1, b0, b1, rr | ready, pal_index, rsp_valid, id, rgb, transparent
        vecs[0] = '{2'b11, 4'h1, 4'h0, 3'd0, 3'd0, 1'b1, 2'b01, 4'h1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[1] = '{2'b11, 4'h1, 4'h0, 3'd0, 3'd0, 1'b1, 2'b10, 4'h0, 1'b1, 1'b1, 12'hFFF, 1'b1};
        vecs[2] = '{2'b11, 4'h1, 4'h0, 3'd0, 3'd0, 1'b1, 2'b01, 4'h1, 1'b1, 1'b0, 12'h000, 1'b0};
        vecs[3] = '{2'b11, 4'h1, 4'h0, 3'd0, 3'd0, 1'b1, 2'b10, 4'h0, 1'b1, 1'b1, 12'hFFF, 1'b1};
        vecs[4] = '{2'b00, 4'h1, 4'h7, 3'd0, 3'd3, 1'b1, 2'b00, 4'h7, 1'b0, 1'b0, 12'h000, 1'b0};
        vecs[5] = '{2'b10, 4'h1, 4'h4, 3'd0, 3'd0, 1'b0, 2'b10, 4'h4, 1'b1, 1'b1, 12'h6DF, 1'b0};
        vecs[6] = '{2'b10, 4'h1, 4'h4, 3'd0, 3'd0, 1'b0, 2'b00, 4'h4, 1'b1, 1'b1, 12'h6DF, 1'b0};
        vecs[7] = '{2'b10, 4'h1, 4'h4, 3'd0, 3'd0, 1'b1, 2'b10, 4'h4, 1'b1, 1'b1, 12'h6DF, 1'b0};
        vecs[8] = '{2'b01, 4'h4, 4'h4, 3'd2, 3'd0, 1'b1, 2'b01, 4'h4, 1'b1, 1'b0, 12'h4DD, 1'b0};

        // Reset holds req_ready low and clears the response slot
        Reset_n = 1'b0;
        drive(2'b11, 4'h4, 4'h4, 3'd0, 3'd0, 1'b1);
        #2;
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id",    32'(bus.rsp_id), 32'd0);
        check("reset_rsp_rgb",   32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'd0);
        check("reset_rsp_tr",    32'(bus.rsp_transparent), 32'd0);

        // Single requester 0, index 4
        do_reset();
        drive(2'b01, 4'h4, 4'h0, 3'd0, 3'd0, 1'b1);
        #2;
        check("single0_req_ready", 32'(bus.req_ready), 32'b01);
        tick();
        check_rsp("single0", 1'b0, 12'h6DF, 1'b0);

        // Directed vector table from a fresh reset
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].v, vecs[k].i0, vecs[k].i1, vecs[k].b0, vecs[k].b1, vecs[k].rr);
            #2;
            check($sformatf("vec%0d_req_ready", k), 32'(bus.req_ready), 32'(vecs[k].exp_ready));
            check($sformatf("vec%0d_pal_index", k), 32'(bus.pal_index), 32'(vecs[k].exp_pidx));
            tick();
            if (vecs[k].exp_rv) begin
                check_rsp($sformatf("vec%0d", k), vecs[k].exp_id, vecs[k].exp_rgb, vecs[k].exp_tr);
            end else begin
                check($sformatf("vec%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
            end
        end

        // Backpressure: held response (id0, 4DD) stays put for 3 cycles
        held_rgb = 12'h4DD;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 4'h2, 4'h3, 3'd1, 3'd1, 1'b0);
            #2;
            check($sformatf("stall%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
            tick();
            check_rsp($sformatf("stall%0d", k), 1'b0, held_rgb, 1'b0);
        end
        drive(2'b11, 4'h2, 4'h3, 3'd1, 3'd1, 1'b1);
        #2;
        check("unstall_req_ready", 32'(bus.req_ready), 32'b10);
        tick();
        check_rsp("unstall", 1'b1, pal_color(4'h3, 3'd1), 1'b0);

        // Reset while a response is held and requester 0 is pending
        drive(2'b01, 4'h2, 4'h3, 3'd1, 3'd1, 1'b0);
        Reset_n = 1'b0;
        #2;
        check("midreset_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset_rsp_id",    32'(bus.rsp_id), 32'd0);
        check("midreset_rsp_rgb",   32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'd0);
        check("midreset_rsp_tr",    32'(bus.rsp_transparent), 32'd0);
        Reset_n = 1'b1;
        drive(2'b11, 4'h2, 4'h3, 3'd1, 3'd1, 1'b0);
        #2;
        check("postreset_tie_ready", 32'(bus.req_ready), 32'b01);
        tick();
        check_rsp("postreset", 1'b0, pal_color(4'h2, 3'd1), 1'b0);

        // Requester 1 alone is granted every cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b10, 4'h0, 4'(k + 5), 3'd0, 3'(k), 1'b1);
            #2;
            check($sformatf("solo1_%0d_req_ready", k), 32'(bus.req_ready), 32'b10);
            tick();
            check_rsp($sformatf("solo1_%0d", k), 1'b1, pal_color(4'(k + 5), 3'(k)), 1'b0);
        end

        // Randomized run against the behavioural model
        do_reset();
        for (int r = 0; r < 2; r++) begin
            cv[r]  = 1'b0;
            acc[r] = 1'b0;
            ci[r]  = 4'h0;
            cb[r]  = 3'd0;
        end
        m_last  = 1;
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_rgb   = '0;
        m_tr    = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                // A requester keeps its request stable until it is accepted.
                if (!cv[r] || acc[r]) begin
                    cv[r] = ($urandom_range(0, 9) < 6);
                    ci[r] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                    cb[r] = 3'($urandom_range(0, 7));
                end
            end
            rr_r = ($urandom_range(0, 9) < 7);
            drive({cv[1], cv[0]}, ci[0], ci[1], cb[0], cb[1], rr_r);
            #2;
            // Round-robin: scan requesters starting after the last one served.
            cand.delete();
            for (int k = 1; k <= 2; k++) begin
                int id;
                id = (m_last + k) % 2;
                if (cv[id]) cand.push_back(id);
            end
            got = (!m_valid || rr_r) && (cand.size() > 0);
            g   = got ? cand[0] : m_last;
            exp_ready = got ? 2'(1 << g) : 2'b00;
            check("rnd_req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("rnd_pal_index", 32'(bus.pal_index), 32'(ci[g]));
            check("rnd_pal_bank",  32'(bus.pal_bank),  32'(cb[g]));
            tick();
            acc[0] = exp_ready[0];
            acc[1] = exp_ready[1];
            if (got) begin
                m_valid = 1'b1;
                m_id    = g[0];
                m_rgb   = pal_color(ci[g], cb[g]);
                m_tr    = (ci[g] == 4'h0);
                m_last  = g;
            end else if (rr_r) begin
                m_valid = 1'b0;
            end
            if (m_valid) begin
                check_rsp("rnd", m_id, m_rgb, m_tr);
            end else begin
                check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
